// File: rtl/adder_test_pkg.sv
// Shared definitions for the 16-bit adder test pattern generator and response analyzer:
// operand/sum widths, LFSR/MISR feedback taps, analyzer FSM states and the MISR step.
package adder_test_pkg;

  localparam int OP_W  = 16;
  localparam int SUM_W = 17;

  localparam int MISR_TAP0 = 15;
  localparam int MISR_TAP1 = 14;
  localparam int MISR_TAP2 = 13;
  localparam int MISR_TAP3 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ora_state_t;

  // Carry-out enters through the feedback bit; the low 16 sum bits fold in after the shift.
  function automatic logic [OP_W-1:0] misr_step(input logic [OP_W-1:0] m,
                                                input logic [SUM_W-1:0] s);
    logic fb;
    fb = m[MISR_TAP0] ^ m[MISR_TAP1] ^ m[MISR_TAP2] ^ m[MISR_TAP3] ^ s[SUM_W-1];
    return {m[OP_W-2:0], fb} ^ s[OP_W-1:0];
  endfunction

endpackage

// File: rtl/adder_ora_dly.sv
// Valid+data delay pipe of LATENCY register stages; LATENCY=0 is a straight wire.
// Only the valid bits are reset, so a reset discards everything in flight.
module adder_ora_dly #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  if (LATENCY == 0) begin : gen_wire
    assign out_vld = in_vld;
    assign out_dat = in_dat;
  end else begin : gen_pipe
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]   dat_q [LATENCY];
    logic [WIDTH-1:0]   dat_d [LATENCY];

    always_comb begin
      vld_d[0] = in_vld;
      dat_d[0] = in_dat;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out_dat = dat_q[LATENCY-1];
  end

endmodule

// File: rtl/adder_ora.sv
// Output response analyzer for the 16-bit adder: aligns expected sums, counts patterns/errors,
// captures the first failure. Define ADDER_ORA_MISR_EN to add the 16-bit response MISR.
module adder_ora
  import adder_test_pkg::*;
#(
  parameter int PATTERNS = 128,
  parameter int LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [16:0] sum,
  output logic        done,
  output logic        pass,
  output logic [15:0] pat_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] first_fail_idx,
  output logic [16:0] first_fail_got,
  output logic [16:0] first_fail_exp,
  output logic        overrun,
  output logic [15:0] signature
);

  localparam logic [15:0] LAST_IDX = 16'(PATTERNS - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SUM_W-1:0] exp_in, exp_chk;
  logic             chk_valid;

  assign exp_in = {1'b0, a} + {1'b0, b};

  adder_ora_dly #(.LATENCY(LATENCY), .WIDTH(SUM_W)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_valid),
    .in_dat  (exp_in),
    .out_vld (chk_valid),
    .out_dat (exp_chk)
  );

  ora_state_t  state_q, state_d;
  logic [15:0] pat_cnt_q, pat_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] ff_idx_q, ff_idx_d;
  logic [16:0] ff_got_q, ff_got_d;
  logic [16:0] ff_exp_q, ff_exp_d;
  logic        overrun_q, overrun_d;
  logic        compare, mismatch;

  assign compare  = chk_valid && (state_q != ST_DONE);
  assign mismatch = compare && (sum != exp_chk);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: if (chk_valid) state_d = (pat_cnt_q == LAST_IDX) ? ST_DONE : ST_RUN;
      ST_DONE:         state_d = ST_DONE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == ST_DONE);
    pass = done && (err_cnt_q == 16'd0);
  end

  // Compare stage: counters and first-fail capture update one cycle after chk_valid
  always_comb begin
    pat_cnt_d = pat_cnt_q;
    err_cnt_d = err_cnt_q;
    ff_idx_d  = ff_idx_q;
    ff_got_d  = ff_got_q;
    ff_exp_d  = ff_exp_q;
    overrun_d = overrun_q;
    if (compare) pat_cnt_d = pat_cnt_q + 16'd1;
    if (mismatch) begin
      err_cnt_d = sat_inc(err_cnt_q);
      if (err_cnt_q == 16'd0) begin
        ff_idx_d = pat_cnt_q;
        ff_got_d = sum;
        ff_exp_d = exp_chk;
      end
    end
    if (chk_valid && (state_q == ST_DONE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt_q <= '0;
      err_cnt_q <= '0;
      ff_idx_q  <= '0;
      ff_got_q  <= '0;
      ff_exp_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      pat_cnt_q <= pat_cnt_d;
      err_cnt_q <= err_cnt_d;
      ff_idx_q  <= ff_idx_d;
      ff_got_q  <= ff_got_d;
      ff_exp_q  <= ff_exp_d;
      overrun_q <= overrun_d;
    end
  end

  assign pat_cnt        = pat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;
  assign first_fail_exp = ff_exp_q;
  assign overrun        = overrun_q;

`ifdef ADDER_ORA_MISR_EN
  logic [15:0] misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (compare) misr_d = misr_step(misr_q, sum);
  end

  always_ff @(posedge clk) begin
    if (rst) misr_q <= '0;
    else     misr_q <= misr_d;
  end

  assign signature = misr_q;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: doc/adder_ora.md
# adder_ora

Output response analyzer for the 16-bit adder test bench: the receiving end of the adder test-pattern stream. Samples each applied operand pair, delays it to match the adder's pipeline latency, computes the expected 17-bit sum, and compares it against the adder output. Accumulates pattern and error counts, captures the first failure, and optionally compresses responses into a MISR signature. Synthesizable, so the same block serves simulation and on-chip BIST.

## Interface
Parameters:
- PATTERNS, 128: number of compared patterns after which the run ends (1..65535).
- LATENCY, 1: adder cycles from operands to sum (0..8).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a/b hold a new pattern this cycle.
- a  in  16  operand A applied to adder.
- b  in  16  operand B applied to adder.
- sum  in  17  adder result {cout, sum[15:0]}, aligned LATENCY cycles after its operands.
- done  out  1  run complete (sticky until rst).
- pass  out  1  done && err_cnt==0.
- pat_cnt  out  16  patterns compared.
- err_cnt  out  16  mismatches, saturates at 16'hFFFF.
- first_fail_idx  out  16  pat_cnt value of first mismatch.
- first_fail_got  out  17  sum at first mismatch.
- first_fail_exp  out  17  expected value at first mismatch.
- overrun  out  1  sticky: aligned valid arrived while in DONE.
- signature  out  16  MISR contents.

## Operation
- Delay line: LATENCY-stage register pipe of {in_valid, a+b (17-bit zero-extended add)}; output is chk_valid/exp. LATENCY=0: combinational, same-cycle compare.
- FSM states IDLE, RUN, DONE.
  - IDLE: on chk_valid, compare, go RUN (or DONE if PATTERNS==1).
  - RUN: on each chk_valid compare; on the PATTERNS-th compare go DONE.
  - DONE: done=1; chk_valid sets overrun, counters/MISR frozen. Exit only via rst.
- Compare: mismatch when sum != exp over all 17 bits. On mismatch err_cnt++ (saturating); if err_cnt was 0, capture first_fail_idx=pat_cnt (pre-increment), first_fail_got, first_fail_exp.
- pat_cnt increments on every compare, including mismatches.
- Cycles without chk_valid: no state change; gaps in in_valid are legal.

## Timing
- Reset: all outputs 0, delay pipe valid bits 0, FSM IDLE, MISR 0. Reset mid-run discards in-flight patterns; operands present during rst are not captured.
- Compare result visible in counters/capture registers one cycle after the chk_valid cycle.
- done/pass rise one cycle after the final compare; pass reflects that final compare.
- Counters and first-fail registers are registered outputs, no combinational paths from inputs.

## Configuration
- ADDER_ORA_MISR_EN defined: 16-bit MISR, update on each compare in IDLE/RUN: fb = m[15]^m[14]^m[13]^m[4]^sum[16]; m_next = {m[14:0], fb} ^ sum[15:0]. Polynomial matches the pattern generator LFSR. signature = m.
- Undefined: no MISR registers; signature tied to 16'h0000.

## Structure
- Package adder_test_pkg: OP_W=16, SUM_W=17, LFSR/MISR tap constants (15,14,13,4), FSM state enum.
- Sub-module adder_ora_dly: parameterized valid+data delay pipe (LATENCY, width), reused for any future DUT-alignment needs.

## Test plan
- Golden adder, LATENCY=1, PATTERNS=4: (FFFF,0001),(0000,0000),(8000,8000),(1234,4321) -> sums 1_0000,0_0000,1_0000,0_5555 all match; done=1, pass=1, pat_cnt=4, err_cnt=0.
- Injected fault: cout forced 0 on pattern 2 (8000+8000) -> err_cnt=1, first_fail_idx=2, got=0_0000, exp=1_0000, pass=0.
- LATENCY=3 with in_valid gaps (valid on cycles 0,2,3,7): compares occur on cycles 3,5,6,10; no mismatches.
- Extra pattern after done (PATTERNS=2, three valids) -> overrun=1, pat_cnt stays 2.
- rst asserted mid-run after 5 patterns, then 2 new patterns -> pat_cnt=2, no in-flight pattern compared.
- With ADDER_ORA_MISR_EN, single pattern sum=0_0001 from reset -> signature=16'h0001; without macro signature=0.
